irq_ctrl: RTL and testbench



---
 rtl/irq_ctrl.sv | 130 +++++++++++++
 tb/tb_irq_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Multi-source external interrupt controller for the core's machine external interrupt.
// Per-source enable, edge/level mode, pending and in-service state, with fixed lowest-index-first priority.
module irq_ctrl #(
    parameter int          NUM_SRC   = 8,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
    parameter int          ID_W      = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [63:0]        bus_address,
    input  logic [63:0]        bus_write_data,
    input  logic               bus_write_enable,
    input  logic               bus_read_enable,
    output logic [63:0]        bus_read_data,
    output logic               bus_hit,
    output logic               irq_out,
    output logic [ID_W-1:0]    irq_id
);

    localparam logic [2:0] REG_ENABLE    = 3'd0;
    localparam logic [2:0] REG_MODE      = 3'd1;
    localparam logic [2:0] REG_PENDING   = 3'd2;
    localparam logic [2:0] REG_INSERVICE = 3'd3;
    localparam logic [2:0] REG_CLAIM     = 3'd4;

    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] mode;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] in_service;
    logic [NUM_SRC-1:0] src_prev;

    logic               in_window;
    logic               rd_hit;
    logic               wr_hit;
    logic [2:0]         reg_sel;
    logic [NUM_SRC-1:0] wr_bits;
    logic [ID_W-1:0]    wr_id;
    logic               claim_rd;
    logic               done_wr;

    logic [NUM_SRC-1:0] set_evt;
    logic [NUM_SRC-1:0] claim_mask;
    logic [NUM_SRC-1:0] done_mask;
    logic [NUM_SRC-1:0] pend_clr;
    logic [NUM_SRC-1:0] eligible;
    logic [ID_W-1:0]    id_next;
    logic [63:0]        rdata;
    logic               unused_bits;

    assign in_window   = (bus_address[63:6] == BASE_ADDR[63:6]);
    assign reg_sel     = bus_address[5:3];
    assign rd_hit      = bus_read_enable && in_window;
    assign wr_hit      = bus_write_enable && in_window;
    assign wr_bits     = bus_write_data[NUM_SRC-1:0];
    assign wr_id       = bus_write_data[ID_W-1:0];
    assign claim_rd    = rd_hit && (reg_sel == REG_CLAIM);
    assign done_wr     = wr_hit && (reg_sel == REG_CLAIM);
    assign unused_bits = ^{bus_address[2:0], bus_write_data[63:NUM_SRC]};

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can infer a latch.
        set_evt    = '0;
        claim_mask = '0;
        done_mask  = '0;
        pend_clr   = '0;
        eligible   = '0;
        id_next    = '0;
        rdata      = '0;

        for (int i = 0; i < NUM_SRC; i++) begin
            set_evt[i]    = mode[i] ? (irq_src[i] && !src_prev[i])
                                    : (irq_src[i] && !in_service[i]);
            claim_mask[i] = claim_rd && (irq_id == ID_W'(i + 1));
            done_mask[i]  = done_wr && (wr_id == ID_W'(i + 1)) && in_service[i];
        end

        // Level sources ignore write-1-to-clear; a mode flip drops stale pending state.
        pend_clr = claim_mask;
        if (wr_hit && (reg_sel == REG_PENDING)) pend_clr = pend_clr | (wr_bits & mode);
        if (wr_hit && (reg_sel == REG_MODE))    pend_clr = pend_clr | (wr_bits ^ mode);

        // A source being claimed this cycle must already be gone from the next irq_id.
        eligible = pending & enable & ~in_service & ~claim_mask;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) id_next = ID_W'(i + 1);
        end

        case (reg_sel)
            REG_ENABLE:    rdata = 64'(enable);
            REG_MODE:      rdata = 64'(mode);
            REG_PENDING:   rdata = 64'(pending);
            REG_INSERVICE: rdata = 64'(in_service);
            REG_CLAIM:     rdata = 64'(irq_id);
            default:       rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            enable        <= '0;
            mode          <= '0;
            pending       <= '0;
            in_service    <= '0;
            src_prev      <= '0;
            irq_out       <= 1'b0;
            irq_id        <= '0;
            bus_read_data <= '0;
            bus_hit       <= 1'b0;
        end else begin
            if (wr_hit && (reg_sel == REG_ENABLE)) enable <= wr_bits;
            if (wr_hit && (reg_sel == REG_MODE))   mode   <= wr_bits;

            // Set events take priority over every clear source in the same cycle.
            pending    <= (pending & ~pend_clr) | set_evt;
            in_service <= (in_service & ~done_mask) | claim_mask;
            src_prev   <= irq_src;

            irq_out <= |eligible;
            irq_id  <= id_next;

            if (bus_read_enable || bus_write_enable) begin
                bus_hit       <= in_window;
                bus_read_data <= rd_hit ? rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: reads push expected responses to a scoreboard queue,
// and a negedge monitor pops and compares whenever a read response is due.
module tb_irq_ctrl;

    localparam int          NUM_SRC = 8;
    localparam int          ID_W    = 6;
    localparam logic [63:0] BASE    = 64'h0000_0000_0200_0000;

    localparam logic [5:0] OFF_ENABLE    = 6'h00;
    localparam logic [5:0] OFF_MODE      = 6'h08;
    localparam logic [5:0] OFF_PENDING   = 6'h10;
    localparam logic [5:0] OFF_INSERVICE = 6'h18;
    localparam logic [5:0] OFF_CLAIM     = 6'h20;

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_SRC-1:0] irq_src;
    logic [63:0]        bus_address;
    logic [63:0]        bus_write_data;
    logic               bus_write_enable;
    logic               bus_read_enable;
    logic [63:0]        bus_read_data;
    logic               bus_hit;
    logic               irq_out;
    logic [ID_W-1:0]    irq_id;

    irq_ctrl #(
        .NUM_SRC  (NUM_SRC),
        .BASE_ADDR(BASE),
        .ID_W     (ID_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .irq_src         (irq_src),
        .bus_address     (bus_address),
        .bus_write_data  (bus_write_data),
        .bus_write_enable(bus_write_enable),
        .bus_read_enable (bus_read_enable),
        .bus_read_data   (bus_read_data),
        .bus_hit         (bus_hit),
        .irq_out         (irq_out),
        .irq_id          (irq_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [63:0]     data;
        logic            hit;
        bit              chk_irq;
        logic            out;
        logic [ID_W-1:0] id;
    } rd_exp_t;

    rd_exp_t sb_q[$];
    rd_exp_t mon_e;
    int      errors = 0;
    int      checks = 0;
    logic    rd_q   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // A read response is due one cycle after the strobe.
    always @(posedge clk) rd_q <= reset ? 1'b0 : bus_read_enable;

    always @(negedge clk) begin
        if (rd_q) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: response with empty scoreboard, data 0x%0h", bus_read_data);
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.name, "_data"}, bus_read_data, mon_e.data);
                check({mon_e.name, "_hit"}, 64'(bus_hit), 64'(mon_e.hit));
                if (mon_e.chk_irq) begin
                    check({mon_e.name, "_irq_out"}, 64'(irq_out), 64'(mon_e.out));
                    check({mon_e.name, "_irq_id"}, 64'(irq_id), 64'(mon_e.id));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [5:0] off, input logic [63:0] d);
        bus_address      = BASE + 64'(off);
        bus_write_data   = d;
        bus_write_enable = 1'b1;
        tick(1);
        bus_write_enable = 1'b0;
    endtask

    task automatic bus_rd_addr(input string name, input logic [63:0] addr, input logic [63:0] exp,
                               input logic exp_hit, input bit chk_irq, input logic exp_out,
                               input logic [ID_W-1:0] exp_id);
        rd_exp_t e;
        e.name    = name;
        e.data    = exp;
        e.hit     = exp_hit;
        e.chk_irq = chk_irq;
        e.out     = exp_out;
        e.id      = exp_id;
        sb_q.push_back(e);
        bus_address     = addr;
        bus_read_enable = 1'b1;
        tick(1);
        bus_read_enable = 1'b0;
    endtask

    task automatic bus_rd(input string name, input logic [5:0] off, input logic [63:0] exp);
        bus_rd_addr(name, BASE + 64'(off), exp, 1'b1, 1'b0, 1'b0, '0);
    endtask

    task automatic bus_rd_i(input string name, input logic [5:0] off, input logic [63:0] exp,
                            input logic exp_out, input logic [ID_W-1:0] exp_id);
        bus_rd_addr(name, BASE + 64'(off), exp, 1'b1, 1'b1, exp_out, exp_id);
    endtask

    task automatic sample(input string name, input logic exp_out, input logic [ID_W-1:0] exp_id);
        @(negedge clk);
        check({name, "_irq_out"}, 64'(irq_out), 64'(exp_out));
        check({name, "_irq_id"}, 64'(irq_id), 64'(exp_id));
    endtask

    task automatic pulse(input logic [NUM_SRC-1:0] v);
        irq_src = v;
        tick(1);
        irq_src = '0;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset            = 1'b1;
        irq_src          = '0;
        bus_address      = '0;
        bus_write_data   = '0;
        bus_write_enable = 1'b0;
        bus_read_enable  = 1'b0;
        tick(3);
        reset = 1'b0;

        // Reset state
        sample("reset", 1'b0, '0);
        check("reset_bus_hit", 64'(bus_hit), 64'd0);
        bus_rd_i("rst_enable", OFF_ENABLE, 64'd0, 1'b0, '0);

        // Level source 3: two-cycle latency, claim, complete with line still high
        bus_wr(OFF_ENABLE, 64'hFF);
        irq_src = 8'h04;
        tick(1);
        sample("lvl_n1", 1'b0, '0);
        tick(1);
        sample("lvl_n2", 1'b1, 6'd3);
        bus_rd_i("claim3", OFF_CLAIM, 64'd3, 1'b0, '0);
        bus_rd_i("insvc3", OFF_INSERVICE, 64'h04, 1'b0, '0);
        bus_rd("pend3_level_held", OFF_PENDING, 64'h04);
        bus_wr(OFF_CLAIM, 64'd3);
        sample("cmpl3_n1", 1'b0, '0);
        tick(1);
        sample("cmpl3_n2", 1'b1, 6'd3);
        irq_src = '0;
        tick(1);
        bus_rd("claim3b", OFF_CLAIM, 64'd3);
        bus_wr(OFF_CLAIM, 64'd3);
        bus_rd_i("pend3_cleared", OFF_PENDING, 64'd0, 1'b0, '0);

        // Edge sources 1 and 5 fire together: priority then nesting
        bus_wr(OFF_MODE, 64'h11);
        pulse(8'h11);
        sample("edge_pair", 1'b1, 6'd1);
        bus_rd_i("claim1", OFF_CLAIM, 64'd1, 1'b1, 6'd5);
        bus_rd_i("claim5", OFF_CLAIM, 64'd5, 1'b0, '0);
        bus_rd("insvc_11", OFF_INSERVICE, 64'h11);
        bus_wr(OFF_CLAIM, 64'd1);
        bus_wr(OFF_CLAIM, 64'd5);
        bus_rd_i("insvc_00", OFF_INSERVICE, 64'd0, 1'b0, '0);

        // Edge source 4: edges during service latch a single pending bit
        bus_wr(OFF_MODE, 64'h19);
        pulse(8'h08);
        sample("edge4", 1'b1, 6'd4);
        bus_rd_i("claim4", OFF_CLAIM, 64'd4, 1'b0, '0);
        pulse(8'h08);
        pulse(8'h08);
        bus_rd_i("pend4_single", OFF_PENDING, 64'h08, 1'b0, '0);
        bus_wr(OFF_CLAIM, 64'd4);
        sample("cmpl4_n1", 1'b0, '0);
        tick(1);
        sample("cmpl4_n2", 1'b1, 6'd4);
        bus_rd("claim4b", OFF_CLAIM, 64'd4);
        bus_wr(OFF_CLAIM, 64'd4);

        // Disabled source still pends; write-1-to-clear loses to a same-cycle edge
        bus_wr(OFF_ENABLE, 64'hF7);
        pulse(8'h08);
        tick(1);
        bus_rd_i("pend_disabled", OFF_PENDING, 64'h08, 1'b0, '0);
        irq_src = 8'h08;
        bus_wr(OFF_PENDING, 64'h08);
        irq_src = '0;
        bus_rd("w1c_set_wins", OFF_PENDING, 64'h08);
        bus_wr(OFF_PENDING, 64'h08);
        bus_rd("w1c_clears", OFF_PENDING, 64'd0);

        // Invalid completions, unmapped offsets, out-of-window access
        bus_wr(OFF_ENABLE, 64'hFF);
        pulse(8'h01);
        sample("edge1", 1'b1, 6'd1);
        bus_rd_i("claim1b", OFF_CLAIM, 64'd1, 1'b0, '0);
        bus_wr(OFF_CLAIM, 64'd0);
        bus_wr(OFF_CLAIM, 64'(NUM_SRC + 1));
        bus_wr(OFF_CLAIM, 64'd2);
        bus_rd("insvc_kept", OFF_INSERVICE, 64'h01);
        bus_rd("hole_28", 6'h28, 64'd0);
        bus_wr(6'h28, 64'hFFFF_FFFF_FFFF_FFFF);
        bus_rd("enable_kept", OFF_ENABLE, 64'hFF);
        bus_rd_addr("out_of_window", BASE + 64'h40, 64'd0, 1'b0, 1'b0, 1'b0, '0);

        // Reset while a claim is outstanding and another source pends
        bus_rd("enable_pre_rst", OFF_ENABLE, 64'hFF);
        pulse(8'h10);
        sample("edge5", 1'b1, 6'd5);
        check("rd_data_held", bus_read_data, 64'hFF);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        sample("mid_rst", 1'b0, '0);
        check("mid_rst_bus_hit", 64'(bus_hit), 64'd0);
        check("mid_rst_rd_data", bus_read_data, 64'd0);
        bus_rd("post_rst_enable", OFF_ENABLE, 64'd0);
        bus_rd("post_rst_mode", OFF_MODE, 64'd0);
        bus_rd("post_rst_pending", OFF_PENDING, 64'd0);
        bus_rd_i("post_rst_insvc", OFF_INSERVICE, 64'd0, 1'b0, '0);
        bus_rd("post_rst_claim", OFF_CLAIM, 64'd0);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
